// File: rtl/pipe_hold_ctrl_if.sv
// Pipeline hold/flush control bundle.
// The master side is the pipeline (it raises the stall/redirect events and
// consumes the hold codes); the slave side is pipe_hold_ctrl.
interface pipe_hold_ctrl_if;
  // Events raised by the pipeline stages
  logic        mem_wait_i;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        mdu_start_i;
  logic [5:0]  mdu_cycles_i;
  logic        load_use_i;
  logic        irq_req_i;
  logic [31:0] irq_vec_i;

  // Per-stage hold codes and PC redirect
  logic [1:0]  hold_pc_o;
  logic [1:0]  hold_if_id_o;
  logic [1:0]  hold_id_ex_o;
  logic [1:0]  hold_ex_mem_o;
  logic [1:0]  hold_mem_wb_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        irq_ack_o;
  logic        busy_o;

  modport master (
    output mem_wait_i, jump_req_i, jump_addr_i, mdu_start_i, mdu_cycles_i,
           load_use_i, irq_req_i, irq_vec_i,
    input  hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o,
           jump_flag_o, jump_addr_o, irq_ack_o, busy_o
  );

  modport slave (
    input  mem_wait_i, jump_req_i, jump_addr_i, mdu_start_i, mdu_cycles_i,
           load_use_i, irq_req_i, irq_vec_i,
    output hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o,
           jump_flag_o, jump_addr_o, irq_ack_o, busy_o
  );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: central stall/flush/redirect controller for a 5-stage pipe.
// All outputs are combinational from the registered state/counter and the
// same-cycle events, so hold codes reach the pipeline registers with zero
// latency. Only state_q and cnt_q are registered.
// Optional interrupt entry sequence: define PIPE_HOLD_CTRL_IRQ_EN.
module pipe_hold_ctrl (
  input  logic               clk,
  input  logic               rst,
  pipe_hold_ctrl_if.slave    bus
);

  localparam logic [1:0] HOLD_NO    = 2'b00;
  localparam logic [1:0] HOLD_WAIT  = 2'b01;
  localparam logic [1:0] HOLD_FLUSH = 2'b10;

`ifdef PIPE_HOLD_CTRL_IRQ_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MDU  = 2'd1,
    ST_IRQ  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MDU  = 2'd1
  } state_t;

  // Interrupt inputs have no function without the IRQ sequence.
  logic unused_irq;
  assign unused_irq = ^{bus.irq_req_i, bus.irq_vec_i};
`endif

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;

  // A multi-cycle op needs a stall only when it takes two or more cycles;
  // three or more cycles need the MDU state to count the remainder.
  logic mdu_stall;
  logic mdu_long;
  assign mdu_stall = (bus.mdu_cycles_i >= 6'd2);
  assign mdu_long  = (bus.mdu_cycles_i >= 6'd3);

  // Next-state and counter: frozen by mem_wait, events act only from IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.mem_wait_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.jump_req_i) begin
            state_d = ST_IDLE;
          end else if (bus.mdu_start_i) begin
            if (mdu_long) begin
              state_d = ST_MDU;
              cnt_d   = bus.mdu_cycles_i - 6'd2;
            end
`ifdef PIPE_HOLD_CTRL_IRQ_EN
          end else if (bus.irq_req_i) begin
            state_d = ST_IRQ;
`endif
          end
        end
        ST_MDU: begin
          if (cnt_q <= 6'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
          end else begin
            cnt_d   = cnt_q - 6'd1;
          end
        end
`ifdef PIPE_HOLD_CTRL_IRQ_EN
        ST_IRQ: begin
          state_d = ST_IDLE;
        end
`endif
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  // State and counter registers; reset abandons any sequence immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold codes and redirect: reset flushes everything, mem_wait freezes the
  // front four stages and drains MEM/WB, otherwise the state decides.
  always_comb begin
    bus.hold_pc_o     = HOLD_NO;
    bus.hold_if_id_o  = HOLD_NO;
    bus.hold_id_ex_o  = HOLD_NO;
    bus.hold_ex_mem_o = HOLD_NO;
    bus.hold_mem_wb_o = HOLD_NO;
    bus.jump_flag_o   = 1'b0;
    bus.jump_addr_o   = 32'd0;
    bus.irq_ack_o     = 1'b0;
    bus.busy_o        = 1'b0;

    if (rst) begin
      bus.hold_pc_o     = HOLD_FLUSH;
      bus.hold_if_id_o  = HOLD_FLUSH;
      bus.hold_id_ex_o  = HOLD_FLUSH;
      bus.hold_ex_mem_o = HOLD_FLUSH;
      bus.hold_mem_wb_o = HOLD_FLUSH;
    end else begin
      bus.busy_o = (state_q != ST_IDLE);
      if (bus.mem_wait_i) begin
        bus.hold_pc_o     = HOLD_WAIT;
        bus.hold_if_id_o  = HOLD_WAIT;
        bus.hold_id_ex_o  = HOLD_WAIT;
        bus.hold_ex_mem_o = HOLD_WAIT;
        bus.hold_mem_wb_o = HOLD_FLUSH;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.jump_req_i) begin
              // Wrong-path instructions in IF/ID and ID/EX are discarded.
              bus.jump_flag_o  = 1'b1;
              bus.jump_addr_o  = bus.jump_addr_i;
              bus.hold_if_id_o = HOLD_FLUSH;
              bus.hold_id_ex_o = HOLD_FLUSH;
            end else if (bus.mdu_start_i) begin
              if (mdu_stall) begin
                // Keep the op in EX; bubble into MEM while it computes.
                bus.hold_pc_o     = HOLD_WAIT;
                bus.hold_if_id_o  = HOLD_WAIT;
                bus.hold_id_ex_o  = HOLD_WAIT;
                bus.hold_ex_mem_o = HOLD_FLUSH;
              end
`ifdef PIPE_HOLD_CTRL_IRQ_EN
            end else if (bus.irq_req_i) begin
              // Freeze fetch and squash younger work before redirecting.
              bus.hold_pc_o     = HOLD_WAIT;
              bus.hold_if_id_o  = HOLD_FLUSH;
              bus.hold_id_ex_o  = HOLD_FLUSH;
              bus.hold_ex_mem_o = HOLD_FLUSH;
`endif
            end else if (bus.load_use_i) begin
              // One bubble into EX so the load result can be forwarded.
              bus.hold_pc_o    = HOLD_WAIT;
              bus.hold_if_id_o = HOLD_WAIT;
              bus.hold_id_ex_o = HOLD_FLUSH;
            end
          end
          ST_MDU: begin
            bus.hold_pc_o     = HOLD_WAIT;
            bus.hold_if_id_o  = HOLD_WAIT;
            bus.hold_id_ex_o  = HOLD_WAIT;
            bus.hold_ex_mem_o = HOLD_FLUSH;
          end
`ifdef PIPE_HOLD_CTRL_IRQ_EN
          ST_IRQ: begin
            bus.jump_flag_o  = 1'b1;
            bus.jump_addr_o  = bus.irq_vec_i;
            bus.irq_ack_o    = 1'b1;
            bus.hold_if_id_o = HOLD_FLUSH;
          end
`endif
          default: begin
            bus.hold_pc_o = HOLD_NO;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pipe_hold_ctrl.md
PIPE_HOLD_CTRL -- requirements
Module: pipe_hold_ctrl

Interface
REQ-001 SHALL provide these ports; clock and reset are fixed as: one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_wait_i  in  1  MEM stage bus access not complete
- jump_req_i  in  1  EX stage taken branch/jump
- jump_addr_i  in  32  EX branch/jump target
- mdu_start_i  in  1  EX issues multi-cycle mul/div
- mdu_cycles_i  in  6  mul/div latency N in cycles
- load_use_i  in  1  ID instruction needs a load result still in EX
- irq_req_i  in  1  level interrupt request (IRQ_EN only)
- irq_vec_i  in  32  interrupt target address (IRQ_EN only)
- hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o  out  2 each  per-stage hold code
- jump_flag_o  out  1  PC redirect this cycle
- jump_addr_o  out  32  redirect target
- irq_ack_o  out  1  one-cycle interrupt accept pulse
- busy_o  out  1  state != IDLE
REQ-002 SHALL use hold codes hold_no=2'b00, hold_wait=2'b01 (register keeps value), hold_flush=2'b10 (register loads default).

Function
REQ-003 SHALL register only state (IDLE, MDU, IRQ) and 6-bit counter cnt; all outputs combinational from state, cnt and same-cycle inputs (zero-cycle latency into pipeline-register hold inputs).
REQ-004 SHALL drive every output to hold_no / 0 unless a rule below applies.
REQ-005 Priority in IDLE: mem_wait_i > jump_req_i > mdu_start_i > irq_req_i > load_use_i; only the highest pending event acts.
REQ-006 mem_wait_i=1 (any state): pc, if_id, id_ex, ex_mem = wait; mem_wb = flush; jump_flag_o=0; state, cnt and IRQ sequence frozen.
REQ-007 jump_req_i in IDLE: jump_flag_o=1, jump_addr_o=jump_addr_i; if_id, id_ex = flush; pc = hold_no.
REQ-008 mdu_start_i in IDLE, N=mdu_cycles_i: N<=1 no action; N>=2 pc, if_id, id_ex = wait, ex_mem = flush this cycle; N=2 stays IDLE; N>=3 loads cnt=N-2 and moves to MDU.
REQ-009 MDU: same holds as REQ-008 each non-mem_wait cycle; cnt decrements; cnt==1 is the last stall, next state IDLE. Total stall = N-1 non-mem_wait cycles.
REQ-010 load_use_i in IDLE: pc, if_id = wait; id_ex = flush; exactly one cycle per assertion cycle.
REQ-011 jump_req_i, mdu_start_i, load_use_i SHALL be ignored outside IDLE (the EX/ID instructions are frozen by the holds).
REQ-012 busy_o=1 in MDU and IRQ.

Reset
REQ-013 rst=1: state=IDLE, cnt=0 immediately (asynchronous), regardless of edge.
REQ-014 While rst=1 all hold outputs = hold_flush; jump_flag_o, irq_ack_o, busy_o = 0; jump_addr_o = 0.
REQ-015 rst mid-MDU or mid-IRQ SHALL abandon the sequence; no irq_ack_o pulse after release.

Configuration
REQ-016 Macro PIPE_HOLD_CTRL_IRQ_EN defined: irq_req_i in IDLE (highest remaining priority) -> cycle 1 in IRQ entry: pc = wait, if_id, id_ex, ex_mem = flush, go IRQ; cycle 2 (IRQ): jump_flag_o=1, jump_addr_o=irq_vec_i, irq_ack_o=1, if_id flush, next IDLE.
REQ-017 Macro undefined: irq_req_i/irq_vec_i ignored, IRQ state absent, irq_ack_o tied 0.

Verification
REQ-018 load_use_i=1 one cycle -> that cycle hold_pc_o=hold_if_id_o=01, hold_id_ex_o=10; next cycle all 00.
REQ-019 mdu_start_i=1, mdu_cycles_i=5 -> 4 consecutive cycles pc/if_id/id_ex=01, ex_mem=10, busy_o=1 on cycles 2-4; cycle 5 all 00, state IDLE.
REQ-020 MDU cnt=2 with mem_wait_i=1 for 3 cycles -> ex_mem=01, mem_wb=10, cnt held at 2; after release 2 more stall cycles then IDLE.
REQ-021 jump_req_i=1, jump_addr_i=32'h0000_0100 with load_use_i=1 same cycle -> jump_flag_o=1, jump_addr_o=0x100, if_id=id_ex=10, hold_pc_o=00.
REQ-022 IRQ_EN, irq_req_i=1, irq_vec_i=32'h0000_0040 in IDLE -> cycle 1 flushes if_id/id_ex/ex_mem; cycle 2 jump_flag_o=1, jump_addr_o=0x40, irq_ack_o=1; rst pulse between cycle 1 and 2 -> no irq_ack_o.
